// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational ALU between two requesters (port 0 = execute
// path, port 1 = branch/address helper). Round-robin arbitration, one ALU
// operation per cycle, results registered into a per-port response slot
// (1-cycle latency).
//
// Handshake rule (both request and response channels): a transfer happens
// in a cycle where valid and ready are both high at the rising clock edge;
// the initiator holds its payload stable while valid=1 and ready=0.
//
// Optional build macro: ALU_ARB_STATS_EN adds saturating 16-bit grant and
// conflict counters plus a synchronous clear input (stat_clr).

module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTL_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTL_W-1:0]  req0_ctl,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_zero,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTL_W-1:0]  req1_ctl,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_zero,

  output logic [CTL_W-1:0]  alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_grant0,
  output logic [15:0]       stat_grant1,
  output logic [15:0]       stat_conflict
`endif
);

  // Round-robin pointer: 0 means port 0 wins the next conflict.
  logic              r_ptr;

  // Response slots.
  logic              r_rsp0_valid;
  logic [DATA_W-1:0] r_rsp0_data;
  logic              r_rsp0_zero;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp1_data;
  logic              r_rsp1_zero;

  logic              w_elig0;
  logic              w_elig1;
  logic              w_both;
  logic              w_gnt0;
  logic              w_gnt1;

  // A port may issue when its slot is empty or is being drained this cycle.
  assign w_elig0 = req0_valid && (!r_rsp0_valid || rsp0_ready);
  assign w_elig1 = req1_valid && (!r_rsp1_valid || rsp1_ready);
  assign w_both  = w_elig0 && w_elig1;

  // Grant selection: a lone eligible port wins; on conflict the pointer decides.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_both) begin
      w_gnt0 = !r_ptr;
      w_gnt1 = r_ptr;
    end else begin
      w_gnt0 = w_elig0;
      w_gnt1 = w_elig1;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  // ALU operand mux; idle cycles present all-zero inputs.
  always_comb begin
    alu_ctl = '0;
    alu_a   = '0;
    alu_b   = '0;
    if (w_gnt0) begin
      alu_ctl = req0_ctl;
      alu_a   = req0_a;
      alu_b   = req0_b;
    end else if (w_gnt1) begin
      alu_ctl = req1_ctl;
      alu_a   = req1_a;
      alu_b   = req1_b;
    end
  end

  // Pointer moves to the losing port only after a real conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_both) begin
      r_ptr <= w_gnt0;
    end
  end

  // Port 0 slot: refill on grant, otherwise clear valid on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp0_zero  <= 1'b0;
    end else if (w_gnt0) begin
      r_rsp0_valid <= 1'b1;
      r_rsp0_data  <= alu_out;
      r_rsp0_zero  <= alu_zero;
    end else if (r_rsp0_valid && rsp0_ready) begin
      r_rsp0_valid <= 1'b0;
    end
  end

  // Port 1 slot: refill on grant, otherwise clear valid on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= '0;
      r_rsp1_zero  <= 1'b0;
    end else if (w_gnt1) begin
      r_rsp1_valid <= 1'b1;
      r_rsp1_data  <= alu_out;
      r_rsp1_zero  <= alu_zero;
    end else if (r_rsp1_valid && rsp1_ready) begin
      r_rsp1_valid <= 1'b0;
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_data  = r_rsp0_data;
  assign rsp0_zero  = r_rsp0_zero;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_data  = r_rsp1_data;
  assign rsp1_zero  = r_rsp1_zero;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_stat_grant0;
  logic [15:0] r_stat_grant1;
  logic [15:0] r_stat_conflict;

  // Saturating usage counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_grant0   <= '0;
      r_stat_grant1   <= '0;
      r_stat_conflict <= '0;
    end else if (stat_clr) begin
      r_stat_grant0   <= '0;
      r_stat_grant1   <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (w_gnt0 && (r_stat_grant0 != 16'hFFFF)) begin
        r_stat_grant0 <= r_stat_grant0 + 16'd1;
      end
      if (w_gnt1 && (r_stat_grant1 != 16'hFFFF)) begin
        r_stat_grant1 <= r_stat_grant1 + 16'd1;
      end
      if (w_both && (r_stat_conflict != 16'hFFFF)) begin
        r_stat_conflict <= r_stat_conflict + 16'd1;
      end
    end
  end

  assign stat_grant0   = r_stat_grant0;
  assign stat_grant1   = r_stat_grant1;
  assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter. The bench plays the ALU itself and keeps
// a transaction-level model of the two response slots and the round-robin
// preference. Build with +define+ALU_ARB_STATS_EN to include counter tests.

module tb_alu_share_arbiter;

  localparam int DW = 32;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
  logic [CW-1:0] req0_ctl;
  logic [DW-1:0] req0_a, req0_b, rsp0_data;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
  logic [CW-1:0] req1_ctl;
  logic [DW-1:0] req1_a, req1_b, rsp1_data;
  logic [CW-1:0] alu_ctl;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic          alu_zero;
`ifdef ALU_ARB_STATS_EN
  logic          stat_clr;
  logic [15:0]   stat_grant0, stat_grant1, stat_conflict;
`endif

  alu_share_arbiter #(.DATA_W(DW), .CTL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp0_zero(rsp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rsp1_zero(rsp1_zero),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_clr(stat_clr), .stat_grant0(stat_grant0),
    .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  // ---------------- behavioural ALU ----------------
  function automatic logic [DW-1:0] alu_fn(input logic [CW-1:0] c,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0110: return a - b;
      4'b1010: return a + b;
      default: return '0;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_ctl, alu_a, alu_b);
  assign alu_zero = (alu_out == '0);

  // ---------------- reference model / scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int last_g   = -1;     // port granted in the last modelled cycle, -1 none
  int m_pref   = 0;      // port preferred on the next conflict
  logic          m_full[2];
  logic [DW-1:0] m_data[2];
  logic          m_zero[2];
  int m_cnt_g0 = 0, m_cnt_g1 = 0, m_cnt_conf = 0;

  task automatic model_reset();
    m_pref = 0;
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
      m_zero[i] = 1'b0;
    end
    m_cnt_g0 = 0; m_cnt_g1 = 0; m_cnt_conf = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int p, input logic v, input logic [CW-1:0] c,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (p == 0) begin
      req0_valid = v; req0_ctl = c; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_ctl = c; req1_a = a; req1_b = b;
    end
  endtask

  task automatic drive_rsp(input logic r0, input logic r1);
    rsp0_ready = r0;
    rsp1_ready = r1;
  endtask

  // One clock cycle: called at posedge+1 with inputs already driven.
  // Checks the same-cycle grant and ALU drive, then the registered slots.
  task automatic do_cycle(input string tag);
    logic want_valid[2];
    logic want_ready[2];
    logic [CW-1:0] c[2];
    logic [DW-1:0] a[2], b[2];
    logic [CW-1:0] e_ctl;
    logic [DW-1:0] e_a, e_b, res;
    int n_elig, g;
    logic elig[2];
    #2;
    want_valid[0] = req0_valid; want_valid[1] = req1_valid;
    want_ready[0] = rsp0_ready; want_ready[1] = rsp1_ready;
    c[0] = req0_ctl; a[0] = req0_a; b[0] = req0_b;
    c[1] = req1_ctl; a[1] = req1_a; b[1] = req1_b;
    n_elig = 0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = want_valid[i] && (!m_full[i] || want_ready[i]);
      if (elig[i]) n_elig++;
    end
    if (n_elig == 2)   g = m_pref;
    else if (elig[0])  g = 0;
    else if (elig[1])  g = 1;
    else               g = -1;
    e_ctl = (g >= 0) ? c[g] : '0;
    e_a   = (g >= 0) ? a[g] : '0;
    e_b   = (g >= 0) ? b[g] : '0;
    checks += 5;
    if (req0_ready !== (g == 0)) begin
      failures++; $display("FAIL %s req0_ready got=%b exp=%b", tag, req0_ready, g == 0);
    end
    if (req1_ready !== (g == 1)) begin
      failures++; $display("FAIL %s req1_ready got=%b exp=%b", tag, req1_ready, g == 1);
    end
    if (alu_ctl !== e_ctl) begin
      failures++; $display("FAIL %s alu_ctl got=%h exp=%h", tag, alu_ctl, e_ctl);
    end
    if (alu_a !== e_a) begin
      failures++; $display("FAIL %s alu_a got=%h exp=%h", tag, alu_a, e_a);
    end
    if (alu_b !== e_b) begin
      failures++; $display("FAIL %s alu_b got=%h exp=%h", tag, alu_b, e_b);
    end
    @(posedge clk);
    // Slot bookkeeping: drains first, a grant then (re)fills its slot.
    for (int i = 0; i < 2; i++) begin
      if (m_full[i] && want_ready[i]) m_full[i] = 1'b0;
      if (g == i) begin
        res = alu_fn(c[i], a[i], b[i]);
        m_full[i] = 1'b1;
        m_data[i] = res;
        m_zero[i] = (res == '0);
      end
    end
    if (n_elig == 2) begin
      m_pref = 1 - g;
      if (m_cnt_conf < 65535) m_cnt_conf++;
    end
    if (g == 0 && m_cnt_g0 < 65535) m_cnt_g0++;
    if (g == 1 && m_cnt_g1 < 65535) m_cnt_g1++;
    last_g = g;
    #1;
    checks += 6;
    if (rsp0_valid !== m_full[0]) begin
      failures++; $display("FAIL %s rsp0_valid got=%b exp=%b", tag, rsp0_valid, m_full[0]);
    end
    if (rsp0_data !== m_data[0]) begin
      failures++; $display("FAIL %s rsp0_data got=%h exp=%h", tag, rsp0_data, m_data[0]);
    end
    if (rsp0_zero !== m_zero[0]) begin
      failures++; $display("FAIL %s rsp0_zero got=%b exp=%b", tag, rsp0_zero, m_zero[0]);
    end
    if (rsp1_valid !== m_full[1]) begin
      failures++; $display("FAIL %s rsp1_valid got=%b exp=%b", tag, rsp1_valid, m_full[1]);
    end
    if (rsp1_data !== m_data[1]) begin
      failures++; $display("FAIL %s rsp1_data got=%h exp=%h", tag, rsp1_data, m_data[1]);
    end
    if (rsp1_zero !== m_zero[1]) begin
      failures++; $display("FAIL %s rsp1_zero got=%b exp=%b", tag, rsp1_zero, m_zero[1]);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    drive_rsp(1'b0, 1'b0);
`ifdef ALU_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    rst_n = 1'b0;
    model_reset();
    #12;
    checks += 4;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b%b exp=00", rsp0_valid, rsp1_valid);
    end
    if (rsp0_data !== '0 || rsp1_data !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0/0", rsp0_data, rsp1_data);
    end
    if (rsp0_zero !== 1'b0 || rsp1_zero !== 1'b0) begin
      failures++; $display("FAIL reset_zero got=%b%b exp=00", rsp0_zero, rsp1_zero);
    end
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_ctl !== '0) begin
      failures++; $display("FAIL reset_idle got=%b%b ctl=%h exp=00 ctl=0", req0_ready, req1_ready, alu_ctl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    drive_rsp(1'b1, 1'b1);
    drive_req(0, 1'b1, 4'b1010, 32'd5, 32'd7);
    do_cycle("add");
    checks += 3;
    if (last_g !== 0) begin
      failures++; $display("FAIL add_grant got=%0d exp=0", last_g);
    end
    if (rsp0_data !== 32'd12 || rsp0_valid !== 1'b1) begin
      failures++; $display("FAIL add_data got=%0d v=%b exp=12 v=1", rsp0_data, rsp0_valid);
    end
    if (rsp0_zero !== 1'b0) begin
      failures++; $display("FAIL add_zero got=%b exp=0", rsp0_zero);
    end
    drive_req(0, 1'b0, '0, '0, '0);
    do_cycle("add_drain");
  endtask

  task automatic test_zero_compare();
    drive_rsp(1'b1, 1'b1);
    drive_req(1, 1'b1, 4'b0110, 32'd9, 32'd9);
    do_cycle("sub");
    checks += 1;
    if (rsp1_data !== 32'd0 || rsp1_zero !== 1'b1) begin
      failures++; $display("FAIL sub_zero got=%0d z=%b exp=0 z=1", rsp1_data, rsp1_zero);
    end
    drive_req(1, 1'b1, 4'b0101, 32'd3, 32'd8);
    do_cycle("slt");
    checks += 1;
    if (rsp1_data !== 32'd1 || rsp1_zero !== 1'b0) begin
      failures++; $display("FAIL slt got=%0d z=%b exp=1 z=0", rsp1_data, rsp1_zero);
    end
    drive_req(1, 1'b0, '0, '0, '0);
    do_cycle("slt_drain");
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 0, 1, 0};
    drive_rsp(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive_req(0, 1'b1, 4'b1010, DW'(k), 32'd100);
      drive_req(1, 1'b1, 4'b0110, 32'd200, DW'(k));
      do_cycle("rr");
      checks += 1;
      if (last_g !== exp_seq[k]) begin
        failures++; $display("FAIL rr_order cycle=%0d got=%0d exp=%0d", k, last_g, exp_seq[k]);
      end
    end
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    do_cycle("rr_drain");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held;
    drive_rsp(1'b1, 1'b0);
    drive_req(1, 1'b1, 4'b0001, 32'hA0, 32'h05);
    do_cycle("bp_fill");
    held = 32'hA5;
    drive_req(1, 1'b1, 4'b0011, 32'hFF, 32'h0F);
    for (int k = 0; k < 3; k++) begin
      drive_req(0, 1'b1, 4'b1010, DW'(k), 32'd1);
      do_cycle("bp_hold");
      checks += 2;
      if (last_g !== 0) begin
        failures++; $display("FAIL bp_grant cycle=%0d got=%0d exp=0", k, last_g);
      end
      if (rsp1_data !== held) begin
        failures++; $display("FAIL bp_hold_data got=%h exp=%h", rsp1_data, held);
      end
    end
    drive_rsp(1'b1, 1'b1);
    do_cycle("bp_refill");
    checks += 2;
    if (last_g !== 1) begin
      failures++; $display("FAIL bp_refill_grant got=%0d exp=1", last_g);
    end
    if (rsp1_data !== 32'hF0) begin
      failures++; $display("FAIL bp_refill_data got=%h exp=f0", rsp1_data);
    end
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    do_cycle("bp_drain");
  endtask

  task automatic test_random();
    logic [3:0] codes[8] = '{4'h0, 4'h1, 4'h3, 4'h5, 4'h6, 4'hA, 4'hF, 4'h8};
    logic [DW-1:0] ra;
    for (int k = 0; k < 400; k++) begin
      // A request left waiting keeps its payload until it is accepted.
      if (!(req0_valid && last_g != 0)) begin
        ra = (($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom));
        drive_req(0, ($urandom_range(0, 3) != 0), codes[$urandom_range(0, 7)], ra,
                  ($urandom_range(0, 2) == 0) ? ra : DW'($urandom));
      end
      if (!(req1_valid && last_g != 1)) begin
        ra = (($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom));
        drive_req(1, ($urandom_range(0, 3) != 0), codes[$urandom_range(0, 7)], ra,
                  ($urandom_range(0, 2) == 0) ? ra : DW'($urandom));
      end
      drive_rsp($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      do_cycle("rand");
    end
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    drive_rsp(1'b1, 1'b1);
    do_cycle("rand_drain");
  endtask

  task automatic test_reset_midop();
    // Make the pointer prefer port 1 so the post-reset grant is meaningful.
    drive_rsp(1'b1, 1'b1);
    for (int k = 0; k < 2 && m_pref != 1; k++) begin
      drive_req(0, 1'b1, 4'b1010, 32'd1, 32'd1);
      drive_req(1, 1'b1, 4'b1010, 32'd2, 32'd2);
      do_cycle("rst_prep");
    end
    drive_req(1, 1'b0, '0, '0, '0);
    drive_rsp(1'b0, 1'b1);
    drive_req(0, 1'b1, 4'b1010, 32'd20, 32'd22);
    do_cycle("rst_fill");
    drive_req(0, 1'b0, '0, '0, '0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks += 2;
    if (rsp0_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_valid got=%b exp=0", rsp0_valid);
    end
    if (rsp0_data !== '0) begin
      failures++; $display("FAIL rst_mid_data got=%h exp=0", rsp0_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_rsp(1'b1, 1'b1);
    drive_req(0, 1'b1, 4'b0000, 32'hF0F0, 32'hFF00);
    drive_req(1, 1'b1, 4'b0001, 32'h1, 32'h2);
    do_cycle("rst_after");
    checks += 1;
    if (last_g !== 0) begin
      failures++; $display("FAIL rst_after_grant got=%0d exp=0", last_g);
    end
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    do_cycle("rst_drain");
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks += 1;
    if (stat_grant0 !== 16'd0 || stat_grant1 !== 16'd0 || stat_conflict !== 16'd0) begin
      failures++; $display("FAIL stat_reset got=%0d/%0d/%0d exp=0/0/0", stat_grant0, stat_grant1, stat_conflict);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive_rsp(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive_req(0, 1'b1, 4'b1010, 32'd3, 32'd4);
      drive_req(1, 1'b1, 4'b0110, 32'd3, 32'd4);
      do_cycle("stat_conf");
    end
    drive_req(0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      drive_req(1, 1'b1, 4'b0011, DW'(k), 32'd9);
      do_cycle("stat_solo");
    end
    checks += 3;
    if (stat_conflict !== 16'd3) begin
      failures++; $display("FAIL stat_conflict got=%0d exp=3", stat_conflict);
    end
    if (stat_grant0 !== 16'd2) begin
      failures++; $display("FAIL stat_grant0 got=%0d exp=2", stat_grant0);
    end
    if (stat_grant1 !== 16'd3 || stat_grant1 !== 16'(m_cnt_g1)) begin
      failures++; $display("FAIL stat_grant1 got=%0d exp=3", stat_grant1);
    end
    // Clear while a grant is happening: the clear must win.
    stat_clr = 1'b1;
    drive_req(1, 1'b0, '0, '0, '0);
    drive_req(0, 1'b1, 4'b1010, 32'd1, 32'd1);
    do_cycle("stat_clr");
    stat_clr = 1'b0;
    checks += 1;
    if (stat_grant0 !== 16'd0 || stat_grant1 !== 16'd0 || stat_conflict !== 16'd0) begin
      failures++; $display("FAIL stat_clear got=%0d/%0d/%0d exp=0/0/0", stat_grant0, stat_grant1, stat_conflict);
    end
    drive_req(0, 1'b0, '0, '0, '0);
    do_cycle("stat_idle");
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_add();
    test_zero_compare();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_midop();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the main execute path (port 0) and a branch/address helper (port 1).
- Each requester has a valid/ready request channel (ALU control code plus operands) and a valid/ready response channel.
- Arbitration is round-robin, one ALU operation per cycle. The result is registered into a per-port response slot, so latency is 1 cycle.
- Drives the ALU's control/operand inputs and samples its result/zero outputs.

Parameters:
- DATA_W, 32, operand/result width (must match the ALU).
- CTL_W, 4, ALU control code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_ctl  in  CTL_W  port 0 ALU control code.
- req0_a  in  DATA_W  port 0 operand A.
- req0_b  in  DATA_W  port 0 operand B.
- rsp0_valid  out  1  port 0 response slot full.
- rsp0_ready  in  1  port 0 consumer takes the response.
- rsp0_data  out  DATA_W  port 0 result.
- rsp0_zero  out  1  port 0 zero flag.
- req1_* / rsp1_*  (same set as port 0)  port 1 equivalents.
- alu_ctl  out  CTL_W  to the ALU control input.
- alu_a  out  DATA_W  to ALU operand A.
- alu_b  out  DATA_W  to ALU operand B.
- alu_out  in  DATA_W  ALU result.
- alu_zero  in  1  ALU zero flag.

Behaviour:
- Reset (rst_n low, async): rsp0_valid = rsp1_valid = 0, rsp*_data = 0, rsp*_zero = 0, round-robin pointer = 0 (port 0 preferred first). Takes effect immediately, even mid-operation. Any response held in a slot is discarded. An in-flight grant is dropped and not replayed.
- Eligibility: port i is eligible when reqi_valid = 1 AND (rspi_valid = 0 OR rspi_ready = 1). Draining and refilling a slot in the same cycle is allowed.
- Grant (combinational, same cycle):
  - If only one port is eligible, grant it.
  - If both are eligible, grant the port indicated by the pointer.
  - reqi_ready = 1 only for the granted port; the other is 0.
  - At most one reqi_ready is high per cycle.
- ALU drive:
  - alu_ctl/alu_a/alu_b are muxed from the granted port.
  - With no grant: alu_ctl = 0, alu_a = 0, alu_b = 0.
  - Control codes pass through unmodified; undefined codes produce whatever the ALU returns (0).
- Capture: on the clock edge following a grant of port i, rspi_data <= alu_out, rspi_zero <= alu_zero, rspi_valid <= 1.
- Slot hold: data and zero stay stable while rspi_valid = 1 and rspi_ready = 0.
- Slot drain: rspi_valid = 1 AND rspi_ready = 1 with no new grant to port i -> rspi_valid <= 0; data and zero keep their last value.
- Pointer update: only when both ports were eligible and a grant occurred. The pointer then moves to the non-granted port. A single-eligible grant leaves the pointer unchanged.
- Fairness bound: a continuously eligible port is granted within 2 cycles.
- Neither port eligible: no grant, no state change except slot drains.
- Requesters must hold ctl/a/b stable while reqi_valid = 1 and reqi_ready = 0. The block does not check this.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_grant0 [15:0], stat_grant1 [15:0] and stat_conflict [15:0].
  - stat_grant0/stat_grant1 count grants per port.
  - stat_conflict counts cycles where both ports were eligible.
  - All three saturate at 16'hFFFF and reset to 0 asynchronously.
  - Adds input stat_clr: synchronous clear of all counters. stat_clr has priority over any increment in the same cycle.
- Undefined: these ports and counters do not exist; the grant/data path is identical.

Test Plan:
- Single add: port 0 only, ctl 4'b1010, a = 5, b = 7 -> req0_ready = 1 in the same cycle; next cycle rsp0_valid = 1, rsp0_data = 12, rsp0_zero = 0.
- Zero and compare: port 1 sub 9-9 -> rsp1_data = 0, rsp1_zero = 1. Then slt 3,8 (ctl 4'b0101) -> rsp1_data = 1, rsp1_zero = 0.
- Round-robin: both valid for 4 cycles, rsp*_ready = 1 -> grants 0,1,0,1; pointer ends at 0.
- Backpressure:
  - Setup: rsp1_valid = 1, rsp1_ready = 0; req1 and req0 both valid.
  - Expect req1_ready = 0, port 0 granted every cycle, rsp1_data unchanged.
  - Raise rsp1_ready -> port 1 granted that same cycle (drain + refill).
- Reset mid-op: assert rst_n low between cycles while rsp0_valid = 1 -> rsp0_valid = 0 immediately, no clock needed. After release, both valid -> port 0 granted first.
- Stats (ALU_ARB_STATS_EN): 3 conflict cycles plus 2 solo port-1 grants -> stat_conflict = 3, stat_grant0 = 2, stat_grant1 = 3. Then stat_clr -> all 0 next cycle.
